// File: rtl/axi_riscv_amos_rmw_seq.sv
// Read-modify-write sequencer for one AXI ATOP at a time; optional AMO_SKIP_SILENT_WRITE_EN drops unchanged writes.
// Latency: accept -> rsp_valid_o in 5 cycles with zero-wait memory, 1 cycle for unsupported ATOPs.
// Backpressure: req_ready_o only in IDLE; rsp held until rsp_ready_i; memory phases hold until mem_gnt_i.
module axi_riscv_amos_rmw_seq #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [5:0]            req_atop_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_operand_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i,
    output logic [5:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_operand_a_o,
    output logic [DATA_WIDTH-1:0] alu_operand_b_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t state_q;
    logic   returns_old;
    logic   atop_ok;

    // Loads and swap return the old word; stores return zero.
    assign returns_old = (alu_op_o[5:4] == 2'b10) || (alu_op_o == 6'b110000);
    assign atop_ok     = (req_atop_i[5:4] == 2'b01) || (req_atop_i[5:4] == 2'b10) ||
                         (req_atop_i == 6'b110000);
    assign mem_wdata_o = mem_we_o ? alu_result_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            req_ready_o     <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_err_o       <= 1'b0;
            rsp_data_o      <= '0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            alu_op_o        <= '0;
            alu_operand_a_o <= '0;
            alu_operand_b_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o     <= 1'b0;
                        alu_op_o        <= req_atop_i;
                        mem_addr_o      <= req_addr_i;
                        alu_operand_b_o <= req_operand_i;
                        alu_operand_a_o <= '0;
                        if (atop_ok) begin
                            state_q   <= RD_REQ;
                            mem_req_o <= 1'b1;
                            mem_we_o  <= 1'b0;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_data_o  <= '0;
                        end
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        alu_operand_a_o <= mem_rdata_i;
                        if (mem_err_i) begin
                            state_q     <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_data_o  <= '0;
                        end else begin
                            state_q  <= WR_REQ;
                            mem_we_o <= 1'b1;
`ifdef AMO_SKIP_SILENT_WRITE_EN
                            // Request withheld one cycle so the ALU sees the registered old word.
                            mem_req_o <= 1'b0;
`else
                            mem_req_o <= 1'b1;
`endif
                        end
                    end
                end
                WR_REQ: begin
                    if (mem_req_o) begin
                        if (mem_gnt_i) begin
                            mem_req_o <= 1'b0;
                            mem_we_o  <= 1'b0;
                            state_q   <= WR_WAIT;
                        end
                    end
`ifdef AMO_SKIP_SILENT_WRITE_EN
                    else if (alu_result_i == alu_operand_a_o) begin
                        mem_we_o    <= 1'b0;
                        state_q     <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_data_o  <= returns_old ? alu_operand_a_o : '0;
                    end else begin
                        mem_req_o <= 1'b1;
                    end
`endif
                end
                WR_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q     <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= rsp_err_o | mem_err_i;
                        rsp_data_o  <= returns_old ? alu_operand_a_o : '0;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        req_ready_o <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_riscv_amos_rmw_seq.sv
// Bench for axi_riscv_amos_rmw_seq: word memory with grant stalls and error injection,
// an ALU stand-in, and a transaction-level reference model of the atomic outcome.
module tb_axi_riscv_amos_rmw_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [5:0]  req_atop_i = '0;
    logic [63:0] req_addr_i = '0;
    logic [63:0] req_operand_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [63:0] rsp_data_o;
    logic        rsp_err_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;
    logic [5:0]  alu_op_o;
    logic [63:0] alu_operand_a_o;
    logic [63:0] alu_operand_b_o;
    logic [63:0] alu_result_i;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];
    int   wr_cnt = 0;
    int   stall_cfg = 0;
    int   stall_cnt = 0;
    logic rd_err_inj = 1'b0;
    logic wr_err_inj = 1'b0;

    always #5 clk_i = ~clk_i;

    axi_riscv_amos_rmw_seq #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_atop_i(req_atop_i),
        .req_addr_i(req_addr_i), .req_operand_i(req_operand_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .alu_op_o(alu_op_o), .alu_operand_a_o(alu_operand_a_o),
        .alu_operand_b_o(alu_operand_b_o), .alu_result_i(alu_result_i)
    );

    function automatic logic [63:0] alu_model(input logic [5:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
        if (op == 6'b110000) return b;
        case (op[2:0])
            3'd0:    return a + b;
            3'd1:    return a & ~b;
            3'd2:    return a ^ b;
            3'd3:    return a | b;
            3'd4:    return ($signed(a) > $signed(b)) ? a : b;
            3'd5:    return ($signed(a) < $signed(b)) ? a : b;
            3'd6:    return (a > b) ? a : b;
            default: return (a < b) ? a : b;
        endcase
    endfunction

    assign alu_result_i = alu_model(alu_op_o, alu_operand_a_o, alu_operand_b_o);
    assign mem_gnt_i    = mem_req_o && (stall_cnt == 0);

    // Grant is withheld for stall_cfg cycles at the start of every request phase.
    always @(posedge clk_i) begin
        if (!mem_req_o || mem_gnt_i) stall_cnt <= stall_cfg;
        else                         stall_cnt <= stall_cnt - 1;
    end

    always @(posedge clk_i) begin
        mem_rvalid_i <= 1'b0;
        mem_err_i    <= 1'b0;
        if (mem_req_o && mem_gnt_i) begin
            mem_rvalid_i <= 1'b1;
            if (mem_we_o) begin
                wr_cnt = wr_cnt + 1;
                if (!wr_err_inj) mem[mem_addr_o] = mem_wdata_o;
                mem_err_i <= wr_err_inj;
            end else begin
                mem_rdata_i <= mem.exists(mem_addr_o) ? mem[mem_addr_o] : 64'h0;
                mem_err_i   <= rd_err_inj;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [63:0] addr, input logic [63:0] val);
        mem[addr]     = val;
        ref_mem[addr] = val;
    endtask

    task automatic send_req(input logic [5:0] atop, input logic [63:0] addr,
                            input logic [63:0] operand);
        int n;
        @(negedge clk_i);
        req_valid_i   = 1'b1;
        req_atop_i    = atop;
        req_addr_i    = addr;
        req_operand_i = operand;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("req_accept", req_ready_o, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic do_amo(input string tag, input logic [5:0] atop, input logic [63:0] addr,
                          input logic [63:0] operand, input int stall, input logic rd_e,
                          input logic wr_e, input int hold, input int exp_lat);
        logic [63:0] old, nw, exp_data, prev_addr, prev_wdata;
        logic        sup, exp_err, saw_req, prev_st;
        int          exp_wr, lat, wr0;
        sup      = (atop[5:4] == 2'b01) || (atop[5:4] == 2'b10) || (atop == 6'b110000);
        old      = ref_mem[addr];
        exp_wr   = 0;
        exp_err  = 1'b0;
        exp_data = '0;
        if (!sup || rd_e) begin
            exp_err = 1'b1;
        end else begin
            nw = alu_model(atop, old, operand);
`ifdef AMO_SKIP_SILENT_WRITE_EN
            exp_wr = (nw != old) ? 1 : 0;
`else
            exp_wr = 1;
`endif
            if (exp_wr == 1) begin
                exp_err = wr_e;
                if (!wr_e) ref_mem[addr] = nw;
            end
            if (atop[5:4] != 2'b01) exp_data = old;
        end
        stall_cfg  = stall;
        rd_err_inj = rd_e;
        wr_err_inj = wr_e;
        wr0        = wr_cnt;
        send_req(atop, addr, operand);
        lat        = 1;
        saw_req    = 1'b0;
        prev_st    = 1'b0;
        prev_addr  = '0;
        prev_wdata = '0;
        while (!rsp_valid_o && lat < 200) begin
            chk({tag, "_busy_ready"}, req_ready_o, 0);
            if (mem_req_o) begin
                saw_req = 1'b1;
                chk({tag, "_mem_addr"}, mem_addr_o, addr);
            end
            if (mem_req_o && !mem_gnt_i) begin
                if (prev_st) begin
                    chk({tag, "_stall_addr"}, mem_addr_o, prev_addr);
                    chk({tag, "_stall_wdata"}, mem_wdata_o, prev_wdata);
                end
                prev_st    = 1'b1;
                prev_addr  = mem_addr_o;
                prev_wdata = mem_wdata_o;
            end else begin
                prev_st = 1'b0;
            end
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        chk({tag, "_rsp_valid"}, rsp_valid_o, 1);
        if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
        if (!sup) chk({tag, "_no_mem_req"}, saw_req, 0);
        chk({tag, "_rsp_data"}, rsp_data_o, exp_data);
        chk({tag, "_rsp_err"}, rsp_err_o, exp_err);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk({tag, "_hold_valid"}, rsp_valid_o, 1);
            chk({tag, "_hold_data"}, rsp_data_o, exp_data);
            chk({tag, "_hold_err"}, rsp_err_o, exp_err);
            chk({tag, "_hold_ready"}, req_ready_o, 0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk({tag, "_rsp_done"}, rsp_valid_o, 0);
        chk({tag, "_mem_value"}, mem[addr], ref_mem[addr]);
        chk({tag, "_write_count"}, wr_cnt - wr0, exp_wr);
    endtask

    initial begin
        int          n;
        int          wr0;
        logic [5:0]  a6;
        logic [63:0] ra, rop;
        for (int k = 0; k < 8; k++) preload(64'h40 + 64'(8 * k), {$urandom, $urandom});

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_req_ready", req_ready_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp_err", rsp_err_o, 0);
        chk("reset_mem_req", mem_req_o, 0);
        chk("reset_mem_we", mem_we_o, 0);
        chk("reset_mem_addr", mem_addr_o, 0);
        chk("reset_alu_op", alu_op_o, 0);
        chk("reset_rsp_data", rsp_data_o, 0);
        rst_ni = 1'b1;

        preload(64'h40, 64'd5);
`ifdef AMO_SKIP_SILENT_WRITE_EN
        do_amo("ldadd", 6'b100000, 64'h40, 64'd3, 0, 1'b0, 1'b0, 0, 6);
`else
        do_amo("ldadd", 6'b100000, 64'h40, 64'd3, 0, 1'b0, 1'b0, 0, 5);
`endif
        chk("ldadd_mem8", mem[64'h40], 64'd8);

        preload(64'h48, 64'hDEAD);
        do_amo("swap", 6'b110000, 64'h48, 64'hBEEF, 3, 1'b0, 1'b0, 0, 0);
        chk("swap_mem", mem[64'h48], 64'hBEEF);

        preload(64'h50, -64'sd2);
        do_amo("stsmax", 6'b010100, 64'h50, 64'd1, 0, 1'b0, 1'b0, 0, 0);
        chk("stsmax_mem", mem[64'h50], 64'd1);
        preload(64'h58, -64'sd2);
        do_amo("stsmax_silent", 6'b010100, 64'h58, -64'sd7, 0, 1'b0, 1'b0, 0, 0);
        chk("stsmax_silent_mem", mem[64'h58], -64'sd2);

        do_amo("compare", 6'b110001, 64'h60, 64'd9, 0, 1'b0, 1'b0, 0, 1);
        do_amo("atop_zero", 6'b000000, 64'h60, 64'd9, 0, 1'b0, 1'b0, 0, 1);
        do_amo("rd_err", 6'b100000, 64'h68, 64'd1, 0, 1'b1, 1'b0, 0, 0);
        do_amo("wr_err", 6'b100011, 64'h70, 64'hF0, 1, 1'b0, 1'b1, 0, 0);
        do_amo("rsp_hold", 6'b100010, 64'h78, 64'h1234, 0, 1'b0, 1'b0, 4, 0);

        // Reset pulse while the write request is stalled waiting for grant.
        stall_cfg  = 6;
        rd_err_inj = 1'b0;
        wr_err_inj = 1'b0;
        wr0        = wr_cnt;
        send_req(6'b100000, 64'h40, 64'd1);
        n = 0;
        while (!(mem_req_o && mem_we_o) && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        chk("rst_reached_wr_req", mem_req_o & mem_we_o, 1);
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_mem_req_async", mem_req_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        @(negedge clk_i);
        rst_ni    = 1'b1;
        stall_cfg = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("rst_no_rsp", rsp_valid_o, 0);
        end
        chk("rst_idle_ready", req_ready_o, 1);
        chk("rst_no_write", wr_cnt - wr0, 0);
        chk("rst_mem_kept", mem[64'h40], ref_mem[64'h40]);
        do_amo("after_rst", 6'b100000, 64'h40, 64'd2, 0, 1'b0, 1'b0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 9);
            if (n < 4)       a6 = {3'b100, 3'($urandom)};
            else if (n < 7)  a6 = {3'b010, 3'($urandom)};
            else if (n == 7) a6 = 6'b110000;
            else if (n == 8) a6 = 6'b110001;
            else             a6 = 6'($urandom);
            ra  = 64'h40 + 64'(8 * $urandom_range(0, 7));
            rop = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 3));
            do_amo("random", a6, ra, rop, $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 2), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
